// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, requester sides,
// and the byte-offset width of a word address.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IC_BURST,
        DC_BURST,
        DONE
    } arb_state_t;

    typedef enum logic {
        SIDE_IC,
        SIDE_DC
    } arb_side_t;

    localparam int BYTE_OFF = 2;

endpackage

// File: rtl/line_burst_ctr.sv
// Word index counter for one line burst: clear, advance on each accepted
// word, and flag the last word of the line. Wraps to 0 after the last word.
module line_burst_ctr #(
    parameter int LINE_WORDS = 8,
    localparam int IDX_W = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/writebacks,
// one full-line burst at a time. Optional counters: define CACHE_MEM_ARB_PERF_EN.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_rvalid,
    output logic [DATA_W-1:0]             ic_rdata,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic                          dc_rvalid,
    output logic [DATA_W-1:0]             dc_rdata,
    output logic                          dc_done,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic                          pc_stall,
`ifdef CACHE_MEM_ARB_PERF_EN
    output logic [31:0]                   perf_ic_lines,
    output logic [31:0]                   perf_dc_lines,
    output logic [31:0]                   perf_mem_busy,
`endif
    output logic                          mem_stall
);

    localparam int IDX_W    = $clog2(LINE_WORDS);
    localparam int LINE_OFF = IDX_W + BYTE_OFF;

    arb_state_t               r_state;
    arb_state_t               w_state_next;
    arb_side_t                r_last_gnt;
    arb_side_t                w_gnt_side;
    logic                     w_grant;
    logic [ADDR_W-LINE_OFF-1:0] r_line;
    logic                     r_we;
    logic [ADDR_W-1:0]        w_req_addr;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_last;
    logic                     w_ic_burst;
    logic                     w_dc_burst;
    logic                     w_burst;

    assign w_ic_burst = (r_state == IC_BURST);
    assign w_dc_burst = (r_state == DC_BURST);
    assign w_burst    = w_ic_burst | w_dc_burst;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_gnt_side   = SIDE_IC;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (ic_req && dc_req) begin
                    w_grant    = 1'b1;
                    w_gnt_side = (r_last_gnt == SIDE_IC) ? SIDE_DC : SIDE_IC;
                end else if (dc_req) begin
                    w_grant    = 1'b1;
                    w_gnt_side = SIDE_DC;
                end else if (ic_req) begin
                    w_grant    = 1'b1;
                    w_gnt_side = SIDE_IC;
                end
                if (w_grant) begin
                    w_state_next = (w_gnt_side == SIDE_DC) ? DC_BURST : IC_BURST;
                end
            end
            IC_BURST, DC_BURST: begin
                if (mem_ack && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_req_addr = (w_gnt_side == SIDE_DC) ? dc_addr : ic_addr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_last_gnt <= SIDE_IC;
            r_line     <= '0;
            r_we       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_last_gnt <= w_gnt_side;
                r_line     <= w_req_addr[ADDR_W-1:LINE_OFF];
                r_we       <= (w_gnt_side == SIDE_DC) & dc_we;
            end
        end
    end

    line_burst_ctr #(
        .LINE_WORDS(LINE_WORDS)
    ) u_ctr (
        .clk   (CLK),
        .rst_n (RST),
        .i_clr (r_state == IDLE),
        .i_inc (w_burst & mem_ack),
        .o_idx (w_idx),
        .o_last(w_last)
    );

    // Line base has zero low bits, so the word address is a plain concatenation.
    assign mem_req   = w_burst;
    assign mem_we    = w_dc_burst & r_we;
    assign mem_addr  = w_burst ? {r_line, w_idx, {BYTE_OFF{1'b0}}} : '0;
    assign mem_wdata = w_burst ? dc_wdata : '0;
    assign word_idx  = w_idx;

    assign ic_rvalid = w_ic_burst & mem_ack;
    assign dc_rvalid = w_dc_burst & ~r_we & mem_ack;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

    assign ic_done   = (r_state == DONE) & (r_last_gnt == SIDE_IC);
    assign dc_done   = (r_state == DONE) & (r_last_gnt == SIDE_DC);

    // Stalls follow the raw requests, so they are masked while in reset.
    assign pc_stall  = RST & (ic_req | w_ic_burst);
    assign mem_stall = RST & (dc_req | w_dc_burst);

`ifdef CACHE_MEM_ARB_PERF_EN
    logic [31:0] r_perf_ic;
    logic [31:0] r_perf_dc;
    logic [31:0] r_perf_busy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_perf_ic   <= '0;
            r_perf_dc   <= '0;
            r_perf_busy <= '0;
        end else begin
            if (ic_done && (r_perf_ic != '1)) r_perf_ic <= r_perf_ic + 32'd1;
            if (dc_done && (r_perf_dc != '1)) r_perf_dc <= r_perf_dc + 32'd1;
            if (mem_req && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_ic_lines = r_perf_ic;
    assign perf_dc_lines = r_perf_dc;
    assign perf_mem_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cache_mem_arbiter;

    localparam int LW = 8;

    logic        CLK, RST;
    logic        ic_req, dc_req, dc_we, mem_ack;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata, wb_seed;
    logic        ic_rvalid, ic_done, dc_rvalid, dc_done;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic [2:0]  word_idx;
    logic        mem_req, mem_we, pc_stall, mem_stall;
`ifdef CACHE_MEM_ARB_PERF_EN
    logic [31:0] perf_ic_lines, perf_dc_lines, perf_mem_busy;
`endif

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW)) dut (
        .CLK(CLK), .RST(RST),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
        .word_idx(word_idx), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .pc_stall(pc_stall),
`ifdef CACHE_MEM_ARB_PERF_EN
        .perf_ic_lines(perf_ic_lines), .perf_dc_lines(perf_dc_lines),
        .perf_mem_busy(perf_mem_busy),
`endif
        .mem_stall(mem_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // The D-cache supplies the word selected by word_idx.
    assign dc_wdata = wb_seed ^ ({29'd0, word_idx} * 32'h0101_0101);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the line transfer in progress, the pending done pulse, and who won last.
    bit          m_busy = 0, m_done = 0, m_side = 0, m_we = 0, m_last = 0;
    logic [31:0] m_base = 0;
    int          m_cnt = 0;
    int          m_p_ic = 0, m_p_dc = 0, m_p_busy = 0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy = 0; m_done = 0; m_last = 0; m_cnt = 0;
            m_p_ic = 0; m_p_dc = 0; m_p_busy = 0;
        end else begin
            if (m_busy) m_p_busy++;
            if (m_done && !m_side) m_p_ic++;
            if (m_done && m_side) m_p_dc++;
            if (m_busy) begin
                if (mem_ack) begin
                    m_cnt++;
                    if (m_cnt == LW) begin
                        m_busy = 0; m_done = 1; m_cnt = 0;
                    end
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (ic_req || dc_req) begin
                bit pick;
                pick   = (ic_req && dc_req) ? !m_last : dc_req;
                m_side = pick;
                m_last = pick;
                m_base = (pick ? dc_addr : ic_addr) & ~32'(LW * 4 - 1);
                m_we   = pick ? dc_we : 1'b0;
                m_busy = 1;
                m_cnt  = 0;
            end
        end
    end

    // Observations used by directed checks and by the request agents.
    int   done_log[$];
    int   wi_log[$];
    int   n_writes = 0, n_ic_rv = 0, n_dc_rv = 0;
    bit   seen_ic_done = 0, seen_dc_done = 0;

    always @(negedge CLK) begin
        bit e_req, e_irv, e_drv;
        e_req = RST && m_busy;
        e_irv = e_req && !m_side && mem_ack;
        e_drv = e_req && m_side && !m_we && mem_ack;
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_addr", mem_addr, m_base + 32'(4 * m_cnt));
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, dc_wdata);
            chk("word_idx", word_idx, m_cnt);
        end
        chk("ic_rvalid", ic_rvalid, e_irv);
        chk("dc_rvalid", dc_rvalid, e_drv);
        if (e_irv) chk("ic_rdata", ic_rdata, mem_rdata);
        if (e_drv) chk("dc_rdata", dc_rdata, mem_rdata);
        chk("ic_done", ic_done, RST && m_done && !m_side);
        chk("dc_done", dc_done, RST && m_done && m_side);
        chk("pc_stall", pc_stall, RST && (ic_req || (m_busy && !m_side)));
        chk("mem_stall", mem_stall, RST && (dc_req || (m_busy && m_side)));
`ifdef CACHE_MEM_ARB_PERF_EN
        chk("perf_ic", perf_ic_lines, m_p_ic);
        chk("perf_dc", perf_dc_lines, m_p_dc);
        chk("perf_busy", perf_mem_busy, m_p_busy);
`endif
        if (ic_done) done_log.push_back(0);
        if (dc_done) done_log.push_back(1);
        if (mem_req && mem_ack) begin
            wi_log.push_back(int'(word_idx));
            if (mem_we) n_writes++;
        end
        if (ic_rvalid) n_ic_rv++;
        if (dc_rvalid) n_dc_rv++;
        seen_ic_done = ic_done;
        seen_dc_done = dc_done;
    end

    int ack_mode = 0;   // 0 always, 1 every third cycle, 2 random
    int ack_ctr  = 0;
    bit auto_rel = 1;

    task automatic step();
        @(posedge CLK);
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (ack_ctr % 3 == 2);
            default: mem_ack = 1'($urandom_range(0, 1));
        endcase
        ack_ctr++;
        mem_rdata = $urandom;
        if (auto_rel) begin
            if (seen_ic_done) ic_req = 1'b0;
            if (seen_dc_done) dc_req = 1'b0;
        end
    endtask

    task automatic clear_logs();
        done_log.delete();
        wi_log.delete();
        n_writes = 0; n_ic_rv = 0; n_dc_rv = 0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        ic_req = 0; dc_req = 0; dc_we = 0; mem_ack = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        int t = 0;
        while (done_log.size() < n && t < budget) begin
            step();
            t++;
            @(negedge CLK);
            #1;
        end
        chk("dones_within_budget", done_log.size(), n);
    endtask

    initial begin
        RST = 1'b0;
        ic_req = 1; dc_req = 1; dc_we = 0; mem_ack = 1;
        ic_addr = 0; dc_addr = 0; mem_rdata = 32'hDEAD_BEEF; wb_seed = 0;

        // Outputs held at zero while in reset, even with requests and acks present.
        repeat (2) @(negedge CLK);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc_stall", pc_stall, 0);
        chk("rst_mem_stall", mem_stall, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_word_idx", word_idx, 0);
        chk("rst_ic_rvalid", ic_rvalid, 0);
        do_reset();

        // I-cache refill, zero-wait memory.
        clear_logs(); ack_mode = 0; auto_rel = 1;
        step();
        ic_req = 1; ic_addr = 32'h0000_1034;
        for (int c = 0; c <= 9; c++) begin
            @(negedge CLK);
            if (c <= 8) chk("i_pc_stall", pc_stall, 1);
            if (c >= 1 && c <= 8) begin
                chk("i_mem_addr", mem_addr, 32'h1020 + 32'(4 * (c - 1)));
                chk("i_rvalid", ic_rvalid, 1);
            end
            chk("i_done_cycle", ic_done, 32'(c == 9));
            if (c < 9) step();
        end
        step();
        chk("i_rvalid_count", n_ic_rv, 8);

        // Tie straight after reset: D first, then I.
        do_reset(); clear_logs();
        step();
        ic_req = 1; ic_addr = 32'h0000_4000;
        dc_req = 1; dc_we = 0; dc_addr = 32'h0000_5010;
        run_until(1, 30);
        chk("tie_first_dc", done_log[0], 1);
        step(); step();
        @(negedge CLK);
        chk("tie_mem_stall_low", mem_stall, 0);
        chk("tie_pc_stall_high", pc_stall, 1);
        #1;
        run_until(2, 30);
        chk("tie_second_ic", done_log[1], 0);

        // Writeback with an ack every third cycle.
        do_reset(); clear_logs();
        ack_mode = 1; ack_ctr = 0; wb_seed = 32'hA5A5_0000;
        step();
        dc_req = 1; dc_we = 1; dc_addr = 32'h0000_2000;
        run_until(1, 60);
        chk("wb_writes", n_writes, 8);
        chk("wb_dc_rvalid", n_dc_rv, 0);
        chk("wb_words", wi_log.size(), 8);
        for (int i = 0; i < wi_log.size(); i++) chk("wb_word_idx", wi_log[i], i);
        dc_we = 0;

        // Round robin with both requests held for four lines.
        do_reset(); clear_logs();
        ack_mode = 0; auto_rel = 0;
        step();
        ic_req = 1; ic_addr = 32'h0000_6000;
        dc_req = 1; dc_addr = 32'h0000_7000;
        run_until(4, 80);
        ic_req = 0; dc_req = 0;
        for (int i = 0; i < 4; i++) chk("rr_order", done_log[i], (i % 2 == 0) ? 1 : 0);
        auto_rel = 1;

        // Asynchronous reset in the middle of an I refill.
        do_reset(); clear_logs();
        step();
        ic_req = 1; ic_addr = 32'h0000_3008;
        begin
            int t = 0;
            while (n_ic_rv < 4 && t < 30) begin
                step(); t++;
                @(negedge CLK); #1;
            end
        end
        chk("rmid_words", n_ic_rv, 4);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("rmid_mem_req", mem_req, 0);
        chk("rmid_pc_stall", pc_stall, 0);
        chk("rmid_rvalid", ic_rvalid, 0);
        chk("rmid_word_idx", word_idx, 0);
        chk("rmid_mem_addr", mem_addr, 0);
        repeat (2) step();
        RST = 1'b1;
        chk("rmid_no_done", done_log.size(), 0);
        step();
        @(negedge CLK);
        chk("rmid_restart_idx", word_idx, 0);
        chk("rmid_restart_addr", mem_addr, 32'h0000_3000);
        #1;
        run_until(1, 30);
        chk("rmid_total_words", n_ic_rv, 12);

`ifdef CACHE_MEM_ARB_PERF_EN
        // Two I lines and one D line, zero-wait.
        do_reset(); clear_logs();
        step();
        ic_req = 1; ic_addr = 32'h0000_0100;
        run_until(1, 30);
        dc_req = 1; dc_we = 0; dc_addr = 32'h0000_0200;
        run_until(2, 30);
        ic_req = 1; ic_addr = 32'h0000_0300;
        run_until(3, 30);
        step(); step();
        chk("perf_ic_lines", perf_ic_lines, 2);
        chk("perf_dc_lines", perf_dc_lines, 1);
        chk("perf_mem_busy", perf_mem_busy, 24);
`endif

        // Randomized traffic from both caches against a randomly stalling memory.
        do_reset(); clear_logs();
        ack_mode = 2; auto_rel = 1;
        for (int i = 0; i < 2000; i++) begin
            step();
            wb_seed = $urandom;
            if (!ic_req && $urandom_range(0, 3) == 0) begin
                ic_req = 1; ic_addr = $urandom;
            end
            if (!dc_req && $urandom_range(0, 3) == 0) begin
                dc_req = 1; dc_we = 1'($urandom_range(0, 1)); dc_addr = $urandom;
            end
        end
        chk("rand_progress", 32'(done_log.size() > 20), 1);

        ic_req = 0; dc_req = 0;
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache line refill and the D-cache line refill/writeback.
- Sequences one full-line burst at a time and drives the word index used by the granted cache.
- Raises pipeline stall outputs while a requester's line transfer is pending or in flight.
- Sits between the two cache FSMs and the memory interface.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width (byte addresses step by 4)
LINE_WORDS, 8, words per cache line (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
ic_req  in  1  I-cache line refill request; held until ic_done
ic_addr  in  ADDR_W  I-cache miss address (any word in the line)
ic_rvalid  out  1  current refill word valid (write it into the line)
ic_rdata  out  DATA_W  refill word
ic_done  out  1  one-cycle pulse, I-cache line complete
dc_req  in  1  D-cache line request; held until dc_done
dc_we  in  1  1 = writeback line, 0 = refill line
dc_addr  in  ADDR_W  D-cache line address
dc_wdata  in  DATA_W  writeback word for the current word_idx
dc_rvalid  out  1  current refill word valid
dc_rdata  out  DATA_W  refill word
dc_done  out  1  one-cycle pulse, D-cache line complete
word_idx  out  $clog2(LINE_WORDS)  word index within the line for the granted cache
mem_req  out  1  memory word request; held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data; valid with mem_ack
mem_ack  in  1  word accepted / read data valid
pc_stall  out  1  I-side stall
mem_stall  out  1  D-side stall

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, idx=0, last_gnt=IC, latched request cleared. All outputs 0.
- A reset mid-burst abandons the burst. No done pulse is issued.
- States: IDLE, IC_BURST, DC_BURST, DONE.
- IDLE arbitration:
  - Only one request: grant it.
  - Both requesting: grant the side not equal to last_gnt (round-robin), so D wins the first tie after reset.
  - On grant, latch the line base (addr with low log2(LINE_WORDS)+2 bits cleared), dc_we and side. Set idx=0 and update last_gnt. Next state is the matching burst state.
- Burst states:
  - mem_req=1.
  - mem_addr = base + (idx<<2).
  - mem_we = latched dc_we (0 in IC_BURST).
  - mem_wdata = dc_wdata.
  - word_idx = idx.
- Each cycle with mem_ack=1:
  - Reads assert the granted side's rvalid the same cycle, with rdata = mem_rdata (combinational passthrough).
  - idx increments.
  - An ack at idx==LINE_WORDS-1 moves to DONE (idx wraps to 0).
- mem_ack=0: hold all mem_* outputs stable.
- DONE:
  - Pulse the granted side's done for exactly one cycle, then go to IDLE.
  - A new grant is not evaluated until IDLE (one bubble cycle).
- Requests are sampled only in IDLE. Deasserting req mid-burst is ignored and the line completes.
- Stall outputs:
  - pc_stall = ic_req | state∈{IC_BURST}.
  - mem_stall = dc_req | state∈{DC_BURST}.
  - Both are combinational, and a waiting loser stays stalled.
- Latency: req in IDLE at cycle 0 → burst cycles 1..N → done pulse at cycle N+1, where N = LINE_WORDS with zero-wait acks. Back-to-back grants are separated by the DONE and IDLE cycles.
- mem_ack outside a burst is ignored.
- rvalid is 0 during writebacks.

Optional Feature:
- Macro: CACHE_MEM_ARB_PERF_EN.
- When defined, add three 32-bit outputs: perf_ic_lines, perf_dc_lines and perf_mem_busy.
  - perf_ic_lines and perf_dc_lines increment on the respective done pulse.
  - perf_mem_busy increments every cycle with mem_req=1.
  - All three saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cache_arb_pkg holds:
  - enum arb_state_t {IDLE, IC_BURST, DC_BURST, DONE}
  - enum arb_side_t {SIDE_IC, SIDE_DC}
  - localparam BYTE_OFF=2
- One sub-module: line_burst_ctr. It is the idx counter with clear, ack-increment and a last-word flag, parameterised by LINE_WORDS.

Test Plan:
- I-cache refill: ic_req=1, ic_addr=0x0000_1034, mem_ack=1 every cycle.
  - mem_addr steps 0x1020,0x1024..0x103C.
  - 8 ic_rvalid pulses.
  - ic_done at cycle 9.
  - pc_stall high cycles 0-8.
- Tie after reset: ic_req=dc_req=1 at the same cycle.
  - D-cache granted first.
  - After dc_done, the I-cache is granted.
  - mem_stall drops once dc_req is released and the D burst ends.
- Writeback with waits: dc_we=1, dc_addr=0x2000, mem_ack every 3rd cycle.
  - mem_addr/mem_wdata are held between acks.
  - word_idx follows 0..7.
  - 8 writes total; dc_rvalid never asserted.
- Round-robin fairness: both requests held continuously for 4 lines.
  - Grant order D,I,D,I.
  - One DONE+IDLE gap between bursts.
- Reset mid-burst: drive RST=0 after word 3 of an I refill.
  - All outputs 0 immediately (asynchronous), no ic_done.
  - After release with ic_req held, the burst restarts at idx 0.
- Perf build (CACHE_MEM_ARB_PERF_EN):
  - After 2 I lines and 1 D line with zero-wait acks: perf_ic_lines=2, perf_dc_lines=1, perf_mem_busy=24.
